// File: rtl/opsel_arbiter.sv
// opsel_arbiter: two-requester round-robin arbiter feeding a small ALU
// (ADD/OR/AND/XOR on 8-bit operands) with a single registered result slot.
// Optional macro OPSEL_SAT_ADD_EN: when defined, ADD saturates to 0xFF on
// carry instead of wrapping modulo 256.
module opsel_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_id,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant_valid;
    logic        grant_id;
    logic        slot_open;
    logic        accept;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [1:0]  sel_op;
    logic [8:0]  sum;
    logic [7:0]  alu_data;
    logic        alu_carry;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Next-state and handshake: the slot can take a new op when empty or being drained
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        slot_open  = !rst && ((state == IDLE) || res_ready);
        if (slot_open && grant_valid) begin
            accept = 1'b1;
            if (grant_id) begin
                req1_ready = 1'b1;
            end else begin
                req0_ready = 1'b1;
            end
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (res_ready && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        res_valid = (state == FULL);
        busy      = (state == FULL);
    end

    // Operand mux and ALU for the current winner; result is captured only on accept
    always_comb begin
        sel_a     = grant_id ? req1_a  : req0_a;
        sel_b     = grant_id ? req1_b  : req0_b;
        sel_op    = grant_id ? req1_op : req0_op;
        sum       = {1'b0, sel_a} + {1'b0, sel_b};
        alu_data  = 8'h00;
        alu_carry = 1'b0;
        case (sel_op)
            OP_ADD: begin
                alu_carry = sum[8];
`ifdef OPSEL_SAT_ADD_EN
                alu_data  = sum[8] ? 8'hFF : sum[7:0];
`else
                alu_data  = sum[7:0];
`endif
            end
            OP_OR:   alu_data = sel_a | sel_b;
            OP_AND:  alu_data = sel_a & sel_b;
            OP_XOR:  alu_data = sel_a ^ sel_b;
            default: alu_data = 8'h00;
        endcase
    end

    // State register; reset drops any held result without a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result slot and grant history; reset wins over a same-cycle accept
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data   <= 8'h00;
            res_carry  <= 1'b0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            res_data   <= alu_data;
            res_carry  <= alu_carry;
            res_id     <= grant_id;
            last_grant <= grant_id;
        end
    end

endmodule

// File: tb/tb_opsel_arbiter.sv
// tb_opsel_arbiter: directed tests for opsel_arbiter. Inputs change on the
// falling edge; outputs are sampled on the falling edge or 1ns after it.
module tb_opsel_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [1:0] req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [1:0] req1_op;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_id;
    logic       busy;

    int checks;
    int errors;

`ifdef OPSEL_SAT_ADD_EN
    localparam logic [7:0] EXP_ADD_C8_64 = 8'hFF;
`else
    localparam logic [7:0] EXP_ADD_C8_64 = 8'h2C;
`endif

    opsel_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'b00;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", res_valid, busy);
        end
        checks++;
        if (res_data !== 8'h00 || res_carry !== 1'b0 || res_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_result: got data=%h carry=%b id=%b expected 00 0 0",
                     res_data, res_carry, res_id);
        end
    endtask

    task automatic test_or;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_op = 2'b01;
        res_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL or_grant: got %b%b expected 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 8'hFF ||
            res_carry !== 1'b0 || res_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL or_result: got v=%b busy=%b data=%h c=%b id=%b expected 1 1 ff 0 0",
                     res_valid, busy, res_data, res_carry, res_id);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL or_drain: got v=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_add;
        req1_valid = 1'b1; req1_a = 8'hC8; req1_b = 8'h64; req1_op = 2'b00;
        res_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_grant: got %b%b expected 01", req0_ready, req1_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== EXP_ADD_C8_64 ||
            res_carry !== 1'b1 || res_id !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_result: got v=%b data=%h c=%b id=%b expected 1 %h 1 1",
                     res_valid, res_data, res_carry, res_id, EXP_ADD_C8_64);
        end
        req1_valid = 1'b0; req1_a = 8'h00;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_drain: got v=%b expected 0", res_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic       exp_g;
        logic [7:0] exp_d;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h01; req1_op = 2'b11;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1);
            exp_d = exp_g ? 8'h11 : 8'h03;
            #1;
            checks++;
            if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got %b%b expected %b%b",
                         i, req0_ready, req1_ready, !exp_g, exp_g);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_id !== exp_g || res_data !== exp_d || res_carry !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_result%0d: got v=%b id=%b data=%h c=%b expected 1 %b %h 0",
                         i, res_valid, res_id, res_data, res_carry, exp_g, exp_d);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_drain: got v=%b expected 0", res_valid);
        end
    endtask

    task automatic test_hold;
        req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h0F; req0_op = 2'b10;
        res_ready = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_idle_grant: got %b expected 1", req0_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h0A || res_id !== 1'b0 || res_carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_load: got v=%b data=%h id=%b c=%b expected 1 0a 0 0",
                     res_valid, res_data, res_id, res_carry);
        end
        req0_a = 8'hFF; req0_op = 2'b11;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_ready%0d: got %b%b expected 00", i, req0_ready, req1_ready);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 8'h0A ||
                res_id !== 1'b0 || res_carry !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_stable%0d: got v=%b busy=%b data=%h id=%b c=%b expected 1 1 0a 0 0",
                         i, res_valid, busy, res_data, res_id, res_carry);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_drain: got v=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_reset_full;
        req0_valid = 1'b1; req0_a = 8'h50; req0_b = 8'h05; req0_op = 2'b01;
        res_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (res_data !== 8'h55 || busy !== 1'b1 || res_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstfull_load: got data=%h busy=%b id=%b expected 55 1 0",
                     res_data, busy, res_id);
        end
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h0C; req1_b = 8'h03; req1_op = 2'b11;
        res_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstfull_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'h00 || busy !== 1'b0 ||
            res_carry !== 1'b0 || res_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstfull_clear: got v=%b data=%h busy=%b c=%b id=%b expected 0 00 0 0 0",
                     res_valid, res_data, busy, res_carry, res_id);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstfull_tie: got %b%b expected 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 8'h55) begin
            errors++;
            $display("[TB] FAIL rstfull_first: got v=%b id=%b data=%h expected 1 0 55",
                     res_valid, res_id, res_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstfull_drain: got v=%b expected 0", res_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_or();
        test_add();
        test_back_to_back();
        test_hold();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
